idc_feeder: RTL and testbench
=============================

# idc_feeder

Host-side initiator for the image display controller stream interface. The block holds one 8x8 signed 7-bit image and 15 opcodes loaded over a simple write port. On `start` it drives the controller's `in_valid`/`in_data`/`op` input burst, then captures the controller's 16-pixel `out_valid`/`out_data` response into a result buffer. It sits between a host or testbench register port and the controller, and is used for on-chip self-test and system bring-up.

## Interface
- `TIMEOUT_CYC`, default 1023: maximum number of cycles allowed from `in_valid` falling to the first `out_valid`.
- `clk` in 1: single clock; every register is clocked on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_we` in 1: load strobe. Ignored while `busy`.
- `cfg_addr` in 7: 0–63 selects pixel (row*8+col); 64–78 selects op[0..14]; 79–127 are ignored.
- `cfg_wdata` in 7: pixel value (signed) or opcode (bits [3:0]).
- `start` in 1: single-cycle pulse. Accepted only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse when the transaction ends.
- `err` out 1: sticky status for the last transaction; cleared when `start` is accepted.
- `dut_in_valid` out 1, `dut_in_data` out 7 signed, `dut_op` out 4: stream to the controller.
- `dut_out_valid` in 1, `dut_out_data` in 7 signed: response from the controller.
- `rd_addr` in 4, `rd_data` out 7: combinational read of result[rd_addr].

## Operation
- Storage:
  - pixel buffer: 64x7.
  - op buffer: 15x4.
  - result buffer: 16x7.
  - None of the buffers are reset; they are written only by `cfg_we` or by capture.
- FSM states: IDLE, SEND, WAIT, RECV, FIN.
- IDLE to SEND when `start` is accepted. The send counter `k` (7 bits) is cleared and `err` is cleared.
- SEND:
  - `dut_in_valid`=1.
  - `dut_in_data`=pix[k].
  - `dut_op` = op[k] for k<15, otherwise 0.
  - `k` increments every cycle. After k=63 the FSM goes to WAIT.
  - Exactly 64 valid cycles are driven, with no gaps.
- WAIT:
  - `dut_in_valid`=0; `dut_in_data` and `dut_op` are 0.
  - On `dut_out_valid`=1 the FSM goes to RECV and the same cycle is captured as result[0].
- RECV:
  - Capture result[j] on each cycle with `dut_out_valid`=1. `j` runs 0..15.
  - After result[15] the FSM goes to FIN.
  - If `dut_out_valid` drops before j=15, set `err` and go to FIN. Results not yet captured keep their old contents.
- FIN: pulse `done`, then go to IDLE.
- A `dut_out_valid` high during SEND is a protocol error: set `err`, and keep sending.
- A `dut_out_valid` high in IDLE or FIN is ignored.
- A `start` while `busy` is ignored.
- A `cfg_we` during `busy` is dropped; loaded data is never corrupted mid-transaction.
- `cfg_we` and `start` in the same IDLE cycle: the write completes first, and the new value is transmitted.

## Timing
- Reset values: `dut_in_valid`=0, `dut_in_data`=0, `dut_op`=0, `busy`=0, `done`=0, `err`=0. The FSM is in IDLE and all counters are 0.
- Reset asserted mid-transaction aborts immediately to the reset values. A new `start` is required afterwards.
- All `dut_*` outputs are registered.
- `start` accepted at cycle t gives `dut_in_valid`=1 in cycles t+1..t+64.
- First `dut_out_valid` seen at cycle u gives `done` at cycle u+16 when the response is complete.
- `rd_data` is valid in the same cycle as `rd_addr`. It reflects captures from the previous edge.

## Configuration
- `IDC_FEEDER_TIMEOUT_EN` defined:
  - WAIT runs a 10-bit watchdog.
  - If `TIMEOUT_CYC` cycles pass without `dut_out_valid`, set `err` and go to FIN.
- Undefined:
  - No watchdog; WAIT waits indefinitely.
  - `TIMEOUT_CYC` is unused.

## Structure
- Shared package `idc_pkg` holds:
  - `IMG_DIM`=8, `N_PIX`=64, `N_OP`=15, `N_OUT`=16.
  - `PIX_W`=7, `OP_W`=4.
  - Address bases `CFG_OP_BASE`=64.
  - Opcode enum: MIDPOINT=0, AVERAGE=1, ROT_L=2, ROT_R=3, FLIP=4, UP=5, LEFT=6, DOWN=7, RIGHT=8.
  - FSM state typedef.
- No sub-module is needed. The buffers are flop arrays inside the block.

## Test plan
- Load pix[i]=i-32 and all ops=0, pulse `start`:
  - required: 64 cycles with `dut_in_data` sequencing −32..31;
  - required: `dut_op` = 0 on every cycle;
  - required: `busy` high throughout.
- Load op[0..14]=1..15 mod 9:
  - required: `dut_op` follows the loaded values on cycles 1..15 of SEND;
  - required: `dut_op` = 0 from cycle 16 on.
- Model controller returns 16 valid cycles of values 10..25 after 5 idle cycles:
  - required: result[0..15]=10..25;
  - required: `done` pulses once;
  - required: `err`=0.
- Model drops `dut_out_valid` after 7 samples:
  - required: `err`=1;
  - required: `done` pulses on the drop cycle + 1;
  - required: result[7..15] unchanged.
- Write during `busy`, then read back after `done`:
  - required: the write was ignored.
- `rst_n` low at SEND cycle 30:
  - required: all outputs go to reset values asynchronously;
  - required: a subsequent `start` sends the full 64 cycles.
- `IDC_FEEDER_TIMEOUT_EN` defined and no response:
  - required: `err`=1 and `done` pulse after `TIMEOUT_CYC` WAIT cycles.

Source files
------------

// File: rtl/idc_pkg.sv
// Shared constants, opcode encoding and FSM state encoding for the
// image display controller feeder.
package idc_pkg;

  localparam int IMG_DIM     = 8;
  localparam int N_PIX       = 64;
  localparam int N_OP        = 15;
  localparam int N_OUT       = 16;
  localparam int PIX_W       = 7;
  localparam int OP_W        = 4;
  localparam int CFG_OP_BASE = 64;

  typedef enum logic [3:0] {
    MIDPOINT = 4'd0,
    AVERAGE  = 4'd1,
    ROT_L    = 4'd2,
    ROT_R    = 4'd3,
    FLIP     = 4'd4,
    UP       = 4'd5,
    LEFT     = 4'd6,
    DOWN     = 4'd7,
    RIGHT    = 4'd8
  } opcode_e;

  // Plain vector states so the encoding stays visible to legacy tooling.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_SEND = 3'd1;
  localparam state_t S_WAIT = 3'd2;
  localparam state_t S_RECV = 3'd3;
  localparam state_t S_FIN  = 3'd4;

endpackage

// File: rtl/idc_feeder.sv
// Host-side initiator for the image display controller: loads an 8x8 image
// and 15 opcodes, streams them out on start, captures the 16-pixel response.
// Optional macro IDC_FEEDER_TIMEOUT_EN adds a watchdog on the response wait.
module idc_feeder
  import idc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [6:0]              cfg_addr,
  input  logic [PIX_W-1:0]        cfg_wdata,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    dut_in_valid,
  output logic signed [PIX_W-1:0] dut_in_data,
  output logic [OP_W-1:0]         dut_op,
  input  logic                    dut_out_valid,
  input  logic signed [PIX_W-1:0] dut_out_data,
  input  logic [3:0]              rd_addr,
  output logic signed [PIX_W-1:0] rd_data
);

  state_t state;
  logic [6:0] k;   // index of the element currently on the stream
  logic [3:0] j;   // next result slot to capture

  logic signed [PIX_W-1:0] pix    [N_PIX];
  logic [OP_W-1:0]         ops    [N_OP];
  logic signed [PIX_W-1:0] result [N_OUT];

  logic cfg_ok, pix_wr, op_wr, start_ok, cap;
  logic [6:0] kn;
  logic signed [PIX_W-1:0] pix_first, pix_next;
  logic [OP_W-1:0] op_first, op_next;

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FIN);
  assign start_ok = start && (state == S_IDLE);

  // Loads are only honoured in IDLE so a running transfer never sees changes.
  assign cfg_ok = cfg_we && (state == S_IDLE);
  assign pix_wr = cfg_ok && (cfg_addr < 7'(CFG_OP_BASE));
  assign op_wr  = cfg_ok && (cfg_addr >= 7'(CFG_OP_BASE))
                         && (cfg_addr < 7'(CFG_OP_BASE + N_OP));

  // A write landing in the same cycle as start must reach the stream, so the
  // first element bypasses the buffer when it is the one being written.
  assign pix_first = (pix_wr && cfg_addr[5:0] == 6'd0) ? cfg_wdata : pix[0];
  assign op_first  = (op_wr && cfg_addr[3:0] == 4'd0) ? cfg_wdata[OP_W-1:0] : ops[0];

  assign kn       = k + 7'd1;
  assign pix_next = pix[kn[5:0]];
  assign op_next  = (kn < 7'(N_OP)) ? ops[kn[3:0]] : '0;

  // WAIT captures slot 0 (j is held at 0 there), RECV captures slot j.
  assign cap = dut_out_valid && (state == S_WAIT || state == S_RECV);

  assign rd_data = result[rd_addr];

`ifdef IDC_FEEDER_TIMEOUT_EN
  localparam logic [9:0] WD_LAST = 10'(TIMEOUT_CYC - 1);
  logic [9:0] wd;
`endif

  // Buffers carry no reset; written only by host loads and response capture.
  always_ff @(posedge clk) begin
    if (pix_wr) pix[cfg_addr[5:0]] <= cfg_wdata;
    if (op_wr)  ops[cfg_addr[3:0]] <= cfg_wdata[OP_W-1:0];
    if (cap)    result[j]          <= dut_out_data;
  end

  // Transaction sequencer with registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      k            <= '0;
      j            <= '0;
      err          <= 1'b0;
      dut_in_valid <= 1'b0;
      dut_in_data  <= '0;
      dut_op       <= '0;
`ifdef IDC_FEEDER_TIMEOUT_EN
      wd           <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state        <= S_SEND;
            k            <= '0;
            err          <= 1'b0;
            dut_in_valid <= 1'b1;
            dut_in_data  <= pix_first;
            dut_op       <= op_first;
          end
        end
        S_SEND: begin
          // A response while still sending is a protocol violation; keep going.
          if (dut_out_valid) err <= 1'b1;
          if (k == 7'(N_PIX - 1)) begin
            state        <= S_WAIT;
            k            <= '0;
            j            <= '0;
            dut_in_valid <= 1'b0;
            dut_in_data  <= '0;
            dut_op       <= '0;
`ifdef IDC_FEEDER_TIMEOUT_EN
            wd           <= '0;
`endif
          end else begin
            k           <= kn;
            dut_in_data <= pix_next;
            dut_op      <= op_next;
          end
        end
        S_WAIT: begin
          if (dut_out_valid) begin
            state <= S_RECV;
            j     <= 4'd1;
          end
`ifdef IDC_FEEDER_TIMEOUT_EN
          else if (wd == WD_LAST) begin
            err   <= 1'b1;
            state <= S_FIN;
          end else begin
            wd <= wd + 10'd1;
          end
`endif
        end
        S_RECV: begin
          if (dut_out_valid) begin
            if (j == 4'(N_OUT - 1)) begin
              state <= S_FIN;
              j     <= '0;
            end else begin
              j <= j + 4'd1;
            end
          end else begin
            // Short burst: uncaptured slots keep their previous contents.
            err   <= 1'b1;
            state <= S_FIN;
            j     <= '0;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idc_feeder.sv
// Self-checking bench for idc_feeder: directed transactions against a
// queue/array model of the stream, status flags and result buffer.
module tb_idc_feeder;
  import idc_pkg::*;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic cfg_we;
  logic [6:0] cfg_addr;
  logic [6:0] cfg_wdata;
  logic start;
  logic busy, done, err;
  logic dut_in_valid;
  logic signed [6:0] dut_in_data;
  logic [3:0] dut_op;
  logic dut_out_valid;
  logic signed [6:0] dut_out_data;
  logic [3:0] rd_addr;
  logic signed [6:0] rd_data;

  idc_feeder #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .busy(busy), .done(done), .err(err),
    .dut_in_valid(dut_in_valid), .dut_in_data(dut_in_data), .dut_op(dut_op),
    .dut_out_valid(dut_out_valid), .dut_out_data(dut_out_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct { int d; int o; } ent_t;

  ent_t exp_q[$];
  int   m_pix [64];
  int   m_op  [15];
  int   m_res [16];
  int   obs_data [64];
  int   obs_op   [64];
  int   obs_n;
  bit   exp_busy, exp_done, exp_err;
  bit   chk_en;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: stream must match the queued expectation, status the flags.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) begin
        ent_t e;
        e = exp_q.pop_front();
        chk("in_valid", int'(dut_in_valid), 1);
        chk("in_data", int'(dut_in_data), e.d);
        chk("op", int'(dut_op), e.o);
        if (obs_n < 64) begin
          obs_data[obs_n] = int'(dut_in_data);
          obs_op[obs_n]   = int'(dut_op);
          obs_n++;
        end
      end else begin
        chk("in_valid_idle", int'(dut_in_valid), 0);
        chk("in_data_idle", int'(dut_in_data), 0);
        chk("op_idle", int'(dut_op), 0);
      end
      chk("busy", int'(busy), int'(exp_busy));
      chk("done", int'(done), int'(exp_done));
      chk("err", int'(err), int'(exp_err));
    end
  end

  task automatic cfg_wr(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = 7'(a); cfg_wdata = 7'(d);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 64; i++) cfg_wr(i, m_pix[i]);
    for (int i = 0; i < 15; i++) cfg_wr(64 + i, m_op[i]);
  endtask

  // nv = response length (16 full, 1..15 short, 0 = no response/timeout);
  // spur = SEND cycle carrying a stray out_valid (-1 none).
  task automatic run_txn(input int gap, input int nv, input int base,
                         input bit busy_wr, input int spur);
    start = 1'b1;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    exp_err = 1'b0; exp_busy = 1'b1;
    obs_n = 0;
    for (int i = 0; i < 64; i++) exp_q.push_back('{m_pix[i], (i < 15) ? m_op[i] : 0});
    for (int i = 0; i < 64; i++) begin
      if (busy_wr && i == 5) begin cfg_we = 1'b1; cfg_addr = 7'd1;  cfg_wdata = 7'h3F; end
      if (busy_wr && i == 6) begin cfg_we = 1'b1; cfg_addr = 7'd64; cfg_wdata = 7'd7;  end
      if (i == spur) dut_out_valid = 1'b1;
      tick();
      cfg_we = 1'b0; dut_out_valid = 1'b0;
      if (i == spur) exp_err = 1'b1;
    end
    repeat (gap) tick();
    if (nv == 0) begin
      repeat (TO) tick();
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < nv; i++) begin
        dut_out_valid = 1'b1; dut_out_data = 7'(base + i);
        m_res[i] = base + i;
        tick();
      end
      dut_out_valid = 1'b0; dut_out_data = '0;
      if (nv < 16) begin
        tick();
        exp_err = 1'b1;
      end
    end
    exp_done = 1'b1;
    tick();
    exp_done = 1'b0; exp_busy = 1'b0;
    chk("q_drained", exp_q.size(), 0);
  endtask

  task automatic check_results();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      chk("rd_data", int'(rd_data), m_res[i]);
    end
  endtask

  task automatic rd_lit(input string nm, input int a, input int v);
    rd_addr = 4'(a);
    #1;
    chk(nm, int'(rd_data), v);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running want finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0;
    dut_out_valid = 1'b0; dut_out_data = '0; rd_addr = '0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0; chk_en = 1'b0; obs_n = 0;
    #2;
    chk_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Ramp image, all ops 0, response 10..25 after 5 idle cycles.
    for (int i = 0; i < 64; i++) m_pix[i] = i - 32;
    for (int i = 0; i < 15; i++) m_op[i] = 0;
    load_all();
    run_txn(5, 16, 10, 1'b0, -1);
    check_results();
    chk("lit_first_pix", obs_data[0], -32);
    chk("lit_last_pix", obs_data[63], 31);
    rd_lit("lit_res5", 5, 15);
    chk("lit_err_ok", int'(err), 0);

    // Ops 1..15 mod 9; write pix[0] together with start; busy-time writes;
    // response cut short after 7 samples.
    for (int i = 0; i < 15; i++) begin
      m_op[i] = (i + 1) % 9;
      cfg_wr(64 + i, m_op[i]);
    end
    m_pix[0] = 5;
    cfg_we = 1'b1; cfg_addr = 7'd0; cfg_wdata = 7'd5;
    run_txn(3, 7, 40, 1'b1, -1);
    check_results();
    chk("lit_same_cycle_pix", obs_data[0], 5);
    chk("lit_op0", obs_op[0], 1);
    chk("lit_op8", obs_op[8], 0);
    chk("lit_op14", obs_op[14], 6);
    chk("lit_op15", obs_op[15], 0);
    rd_lit("lit_res6", 6, 46);
    rd_lit("lit_res7_kept", 7, 17);
    chk("lit_err_drop", int'(err), 1);

    // Busy-time writes must not have landed; stray valid during SEND.
    run_txn(0, 16, -8, 1'b0, 10);
    check_results();
    chk("lit_pix1_kept", obs_data[1], -31);
    chk("lit_op0_kept", obs_op[0], 1);
    rd_lit("lit_res0", 0, -8);

    // Asynchronous reset at SEND cycle 30.
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_busy = 1'b1; exp_err = 1'b0;
    for (int i = 0; i < 64; i++) exp_q.push_back('{m_pix[i], (i < 15) ? m_op[i] : 0});
    repeat (30) tick();
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_in_valid", int'(dut_in_valid), 0);
    chk("rst_in_data", int'(dut_in_data), 0);
    chk("rst_op", int'(dut_op), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    exp_q.delete();
    exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    run_txn(2, 16, 20, 1'b0, -1);
    check_results();
    chk("lit_after_rst_cnt", obs_n, 64);

`ifdef IDC_FEEDER_TIMEOUT_EN
    // No response: watchdog ends the wait with err.
    run_txn(0, 0, 0, 1'b0, -1);
    check_results();
    chk("lit_timeout_err", int'(err), 1);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
